// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and sizes for the instruction fetch controller
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int INST_W     = 32;
    localparam int PC_W       = 64;
    localparam int ENTRY_W    = PC_W + INST_W;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush and occupancy count
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - sequential instruction fetch with redirect, bounds fault and 2-deep queue
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 96
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [PC_W-1:0]    Inst_Address,
    input  logic [INST_W-1:0]  Instruction,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INST_W-1:0]  out_inst,
    output logic [PC_W-1:0]    out_pc,
    output logic               fault
);

    // pc + 3 < IMEM_BYTES rewritten as pc < IMEM_BYTES - 3 so a wrapped pc cannot slip through.
    localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(IMEM_BYTES - 3);

    fetch_state_t      state;
    logic [PC_W-1:0]   pc;
    logic [CNT_W-1:0]  count;
    logic [ENTRY_W-1:0] head;
    logic              pop;
    logic              space;
    logic              addr_ok;
    logic              push;

    assign Inst_Address = pc;
    assign out_valid    = (count != '0) && !redirect_valid;
    assign pop          = out_valid && out_ready;
    assign space        = (count != CNT_W'(FIFO_DEPTH)) || pop;
    assign addr_ok      = (pc[1:0] == 2'b00) && (pc < PC_LIMIT);
    assign push         = (state == ST_FETCH) && !redirect_valid && space && addr_ok;
    assign out_pc       = head[ENTRY_W-1:INST_W];
    assign out_inst     = head[INST_W-1:0];

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CW    (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .din     ({pc, Instruction}),
        .dout    (head),
        .count   (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    if (redirect_valid) pc <= redirect_pc;
                end
                ST_FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (space && !addr_ok) begin
                        state <= ST_HALT;
                        fault <= 1'b1;
                    end else if (push) begin
                        pc <= pc + 64'd4;
                    end
                end
                ST_HALT: begin
                    if (redirect_valid) begin
                        state <= ST_FETCH;
                        fault <= 1'b0;
                        pc    <= redirect_pc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed checks of imem_fetch_ctrl with a full and a tiny memory
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [63:0] ia1, ia2;
    logic [31:0] inst1, inst2;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        ov1, ov2;
    logic        ready1 = 1'b0;
    logic        ready2 = 1'b1;
    logic [31:0] oi1, oi2;
    logic [63:0] op1, op2;
    logic        fault1, fault2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Word at 0 is addi x6,x0,1; every other word encodes its own address.
    function automatic logic [31:0] imem_word(input logic [63:0] a, input int bytes);
        if (a[1:0] != 2'b00 || a >= 64'(bytes - 3)) return 32'h0;
        if (a == 64'h0) return 32'h00100313;
        return 32'h1000_0000 | a[31:0];
    endfunction

    assign inst1 = imem_word(ia1, 96);
    assign inst2 = imem_word(ia2, 8);

    imem_fetch_ctrl #(.RESET_PC(64'h0), .IMEM_BYTES(96)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .Inst_Address   (ia1),
        .Instruction    (inst1),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (ov1),
        .out_ready      (ready1),
        .out_inst       (oi1),
        .out_pc         (op1),
        .fault          (fault1)
    );

    imem_fetch_ctrl #(.RESET_PC(64'h0), .IMEM_BYTES(8)) dut_small (
        .clk            (clk),
        .reset_n        (reset_n),
        .Inst_Address   (ia2),
        .Instruction    (inst2),
        .redirect_valid (1'b0),
        .redirect_pc    (64'h0),
        .out_valid      (ov2),
        .out_ready      (ready2),
        .out_inst       (oi2),
        .out_pc         (op2),
        .fault          (fault2)
    );

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ready1 = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (ia1 !== 64'h0) begin miscompares++; $display("FAIL reset_addr got %h want %h", ia1, 64'h0); end
        vectors++; if (ov1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", ov1); end
        vectors++; if (op1 !== 64'h0) begin miscompares++; $display("FAIL reset_out_pc got %h want 0", op1); end
        vectors++; if (oi1 !== 32'h0) begin miscompares++; $display("FAIL reset_out_inst got %h want 0", oi1); end
        vectors++; if (fault1 !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", fault1); end
        reset_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        @(negedge clk);
        vectors++; if (ia1 !== 64'h0) begin miscompares++; $display("FAIL first_addr got %h want 0", ia1); end
        vectors++; if (ov1 !== 1'b0) begin miscompares++; $display("FAIL first_idle_valid got %b want 0", ov1); end
        @(negedge clk);
        vectors++; if (ov1 !== 1'b1) begin miscompares++; $display("FAIL first_valid got %b want 1", ov1); end
        vectors++; if (oi1 !== 32'h00100313) begin miscompares++; $display("FAIL first_inst got %h want 00100313", oi1); end
        vectors++; if (op1 !== 64'h0) begin miscompares++; $display("FAIL first_pc got %h want 0", op1); end
    endtask

    task automatic test_stall();
        repeat (5) @(negedge clk);
        vectors++; if (ia1 !== 64'h8) begin miscompares++; $display("FAIL stall_addr got %h want 8", ia1); end
        vectors++; if (ov1 !== 1'b1) begin miscompares++; $display("FAIL stall_valid got %b want 1", ov1); end
        vectors++; if (op1 !== 64'h0) begin miscompares++; $display("FAIL stall_head_pc got %h want 0", op1); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
        ready1 = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            exp_pc = 64'(i * 4);
            exp_inst = (i == 0) ? 32'h00100313 : (32'h1000_0000 | 32'(i * 4));
            vectors++; if (ov1 !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", i, ov1); end
            vectors++; if (op1 !== exp_pc) begin miscompares++; $display("FAIL stream_pc[%0d] got %h want %h", i, op1, exp_pc); end
            vectors++; if (oi1 !== exp_inst) begin miscompares++; $display("FAIL stream_inst[%0d] got %h want %h", i, oi1, exp_inst); end
        end
        ready1 = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        ready1 = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (op1 !== 64'h0 || ia1 !== 64'h8) begin miscompares++; $display("FAIL redir_full got pc %h addr %h want 0 8", op1, ia1); end
        redirect_valid = 1'b1;
        redirect_pc = 64'h20;
        ready1 = 1'b1;
        #1;
        vectors++; if (ov1 !== 1'b0) begin miscompares++; $display("FAIL redir_valid_mask got %b want 0", ov1); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        vectors++; if (ov1 !== 1'b0) begin miscompares++; $display("FAIL redir_flushed got %b want 0", ov1); end
        vectors++; if (ia1 !== 64'h20) begin miscompares++; $display("FAIL redir_addr got %h want 20", ia1); end
        @(negedge clk);
        vectors++; if (ov1 !== 1'b1 || op1 !== 64'h20) begin miscompares++; $display("FAIL redir_first got valid %b pc %h want 1 20", ov1, op1); end
        vectors++; if (oi1 !== 32'h10000020) begin miscompares++; $display("FAIL redir_inst got %h want 10000020", oi1); end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_pc = 64'h22;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        vectors++; if (fault1 !== 1'b1) begin miscompares++; $display("FAIL fault_set got %b want 1", fault1); end
        vectors++; if (ov1 !== 1'b0) begin miscompares++; $display("FAIL fault_no_push got %b want 0", ov1); end
        @(negedge clk);
        vectors++; if (fault1 !== 1'b1 || ia1 !== 64'h22) begin miscompares++; $display("FAIL fault_hold got fault %b addr %h want 1 22", fault1, ia1); end
        redirect_valid = 1'b1;
        redirect_pc = 64'h10;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        vectors++; if (fault1 !== 1'b0) begin miscompares++; $display("FAIL fault_clear got %b want 0", fault1); end
        @(negedge clk);
        vectors++; if (ov1 !== 1'b1 || op1 !== 64'h10) begin miscompares++; $display("FAIL fault_recover got valid %b pc %h want 1 10", ov1, op1); end
        vectors++; if (oi1 !== 32'h10000010) begin miscompares++; $display("FAIL fault_recover_inst got %h want 10000010", oi1); end
    endtask

    task automatic test_range();
        ready1 = 1'b0;
        do_reset();
        @(negedge clk);
        vectors++; if (ov2 !== 1'b0) begin miscompares++; $display("FAIL range_idle got %b want 0", ov2); end
        @(negedge clk);
        vectors++; if (ov2 !== 1'b1 || op2 !== 64'h0) begin miscompares++; $display("FAIL range_pc0 got valid %b pc %h want 1 0", ov2, op2); end
        @(negedge clk);
        vectors++; if (ov2 !== 1'b1 || op2 !== 64'h4) begin miscompares++; $display("FAIL range_pc4 got valid %b pc %h want 1 4", ov2, op2); end
        vectors++; if (oi2 !== 32'h10000004) begin miscompares++; $display("FAIL range_inst4 got %h want 10000004", oi2); end
        vectors++; if (fault2 !== 1'b0) begin miscompares++; $display("FAIL range_early_fault got %b want 0", fault2); end
        @(negedge clk);
        vectors++; if (fault2 !== 1'b1) begin miscompares++; $display("FAIL range_fault got %b want 1", fault2); end
        vectors++; if (ov2 !== 1'b0) begin miscompares++; $display("FAIL range_drained got %b want 0", ov2); end
        @(negedge clk);
        vectors++; if (ia2 !== 64'h8 || fault2 !== 1'b1) begin miscompares++; $display("FAIL range_hold got addr %h fault %b want 8 1", ia2, fault2); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_back_to_back();
        test_redirect();
        test_fault();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0: first fetch address after reset.
REQ-002 Parameter IMEM_BYTES, default 96: instruction memory size in bytes; fetch addresses SHALL satisfy addr+3 < IMEM_BYTES.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 Inst_Address  output  64  byte address driven to Instruction_Memory.
REQ-006 Instruction  input  32  little-endian word returned combinationally for Inst_Address in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump redirect request, single cycle.
REQ-008 redirect_pc  input  64  redirect target byte address.
REQ-009 out_valid  output  1  fetched instruction available to decode.
REQ-010 out_ready  input  1  decode accepts; transfer SHALL occur when out_valid && out_ready.
REQ-011 out_inst  output  32  head-of-queue instruction.
REQ-012 out_pc  output  64  address of out_inst.
REQ-013 fault  output  1  fetch address misaligned or out of range; controller halted.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, HALT; reset enters IDLE; IDLE SHALL go to FETCH unconditionally after one cycle.
REQ-015 Inst_Address SHALL equal the internal pc register in every state.
REQ-016 A 2-entry FIFO SHALL hold {pc, instruction} pairs; out_* SHALL present the head entry; out_valid = (count != 0) && !redirect_valid.
REQ-017 In FETCH, a push SHALL occur when count < 2, or count == 2 with a pop in the same cycle; on push, the FIFO captures {pc, Instruction} and pc <= pc + 4.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-019 If count == 2 and no pop, pc SHALL hold and no push occurs.
REQ-020 Before a push, if pc[1:0] != 0 or pc+3 >= IMEM_BYTES, no push SHALL occur; FSM enters HALT next cycle with fault = 1.
REQ-021 In HALT, the FIFO SHALL continue to drain through the handshake; no pushes occur.
REQ-022 redirect_valid SHALL take priority over push and pop in the same cycle: FIFO flushed (count <= 0), pc <= redirect_pc, no handshake counted, no push.
REQ-023 Redirect in HALT SHALL clear fault and return to FETCH; a misaligned or out-of-range redirect_pc SHALL re-enter HALT on the next fetch attempt per REQ-020.
REQ-024 pc arithmetic SHALL be 64-bit modulo 2^64; the range check in REQ-020 SHALL catch wrap before any push.
REQ-025 Fetch latency: an instruction at address A SHALL be visible on out_* one cycle after the cycle in which Inst_Address == A and the push occurs.

Reset
REQ-026 On reset_n low, asynchronously: state = IDLE, pc = RESET_PC, count = 0, FIFO pointers = 0, fault = 0, out_valid = 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries; no partial handshake SHALL be reported.
REQ-028 out_inst and out_pc SHALL reset to 0.

Structure
REQ-029 FSM state encoding, FIFO depth (2), and instruction width (32) SHALL live in a shared package imem_pkg.
REQ-030 The FIFO SHALL be the sub-module fetch_fifo (parameterised depth/width, with push, pop, flush, count); FSM and pc logic reside in imem_fetch_ctrl.

Verification
REQ-031 Reset, with word 0x00100313 (addi x6,x0,1) at address 0 -> Inst_Address = 0, out_valid = 0; second cycle after release: out_valid = 1, out_inst = 0x00100313, out_pc = 0.
REQ-032 out_ready = 0 held for 5 cycles -> count = 2 with out_pc 0 then 4 retained; Inst_Address holds at 8; no entry lost when out_ready returns to 1.
REQ-033 FIFO full and out_ready = 1 continuously -> one instruction per cycle, out_pc sequence 0, 4, 8, 12 with no bubbles.
REQ-034 redirect_valid with redirect_pc = 0x20 while full -> out_valid = 0 that cycle; next out_pc = 0x20; entries at 0 and 4 never delivered.
REQ-035 redirect_pc = 0x22 -> fault = 1 next cycle, no push; a subsequent redirect to 0x10 -> fault = 0, out_pc = 0x10.
REQ-036 IMEM_BYTES = 8 with out_ready = 1 -> out_pc 0 and 4 delivered; fault = 1 when pc = 8; Inst_Address stays 8.
